// File: rtl/flash_loader_if.sv
// flash_loader_if: memory-bus write port driven by the boot copier
interface flash_loader_if;
  logic [31:0] address_out;
  logic        sel_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic        ready_in;
  modport master(output address_out, sel_out, write_mask_out, write_value_out, input ready_in);
  modport slave(input address_out, sel_out, write_mask_out, write_value_out, output ready_in);
endinterface

// File: rtl/flash_loader.sv
// flash_loader: boot copier streaming an image from SPI flash (one READ command) into RAM over the memory bus
module flash_loader #(
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter int          WORD_COUNT   = 2048,
  parameter logic [31:0] RAM_BASE     = 32'h0,
  parameter int          CLK_DIV      = 2
) (
  input  logic           clk,
  input  logic           reset,
  output logic           flash_clk_out,
  output logic           flash_csn_out,
  output logic           flash_mosi_out,
  input  logic           flash_miso_in,
  flash_loader_if.master bus,
  output logic           done_out
);
  localparam int IW = $clog2(WORD_COUNT) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  typedef enum logic [2:0] {START, CMD, ADDR, DATA, WRITE, FINISH, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] div, div_n;
  logic [4:0] bits, bits_n;
  logic [31:0] tx, tx_n, data_n, addr_n;
  logic [IW-1:0] idx, idx_n;
  logic [3:0] mask_n;
  logic sck_n, csn_n, sel_n, done_n, tick;
  // command and address leave through one shift register; it drains to zero, so MOSI is 0 during DATA
  assign flash_mosi_out = tx[31];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= START;
      div <= '0;
      bits <= '0;
      tx <= '0;
      idx <= '0;
      flash_clk_out <= 1'b0;
      flash_csn_out <= 1'b1;
      done_out <= 1'b0;
      bus.sel_out <= 1'b0;
      bus.write_mask_out <= '0;
      bus.address_out <= '0;
      bus.write_value_out <= '0;
    end else begin
      state <= state_n;
      div <= div_n;
      bits <= bits_n;
      tx <= tx_n;
      idx <= idx_n;
      flash_clk_out <= sck_n;
      flash_csn_out <= csn_n;
      done_out <= done_n;
      bus.sel_out <= sel_n;
      bus.write_mask_out <= mask_n;
      bus.address_out <= addr_n;
      bus.write_value_out <= data_n;
    end
  always_comb begin
    state_n = state;
    div_n = div;
    bits_n = bits;
    tx_n = tx;
    idx_n = idx;
    sck_n = flash_clk_out;
    csn_n = flash_csn_out;
    done_n = done_out;
    sel_n = bus.sel_out;
    mask_n = bus.write_mask_out;
    addr_n = bus.address_out;
    data_n = bus.write_value_out;
    tick = div == DW'(CLK_DIV - 1);
    case (state)
      START: begin
        csn_n = 1'b0;
        tx_n = {8'h03, FLASH_OFFSET};
        bits_n = '0;
        div_n = '0;
        state_n = CMD;
      end
      CMD, ADDR, DATA: begin
        div_n = tick ? '0 : div + 1'b1;
        if (tick && !flash_clk_out) begin
          sck_n = 1'b1;
          // bytes arrive MSB first, least significant byte first
          if (state == DATA) data_n[{bits[4:3], ~bits[2:0]}] = flash_miso_in;
        end else if (tick) begin
          sck_n = 1'b0;
          tx_n = tx << 1;
          bits_n = bits + 5'd1;
          if (state == CMD && bits == 5'd7) state_n = ADDR;
          if (state == ADDR && bits == 5'd31) state_n = DATA;
          if (state == DATA && bits == 5'd31) begin
            state_n = WRITE;
            sel_n = 1'b1;
            mask_n = 4'b1111;
            addr_n = RAM_BASE + (32'(idx) << 2);
          end
        end
      end
      WRITE: if (bus.ready_in) begin
        sel_n = 1'b0;
        mask_n = '0;
        idx_n = idx + 1'b1;
        csn_n = idx_n == IW'(WORD_COUNT);
        state_n = idx_n == IW'(WORD_COUNT) ? FINISH : DATA;
      end
      FINISH: begin
        done_n = 1'b1;
        state_n = DONE;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: scoreboard bench for two flash_loader builds (CLK_DIV=2 with 4 words, CLK_DIV=1 with 16 words)
module tb_flash_loader;
  logic clk = 0;
  always #5 clk = ~clk;
  int n_chk, n_fail;
  logic [67:0] exp_a[$], exp_b[$];
  logic [7:0] pat[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD = (g == 1) ? 1 : 2;
    localparam int WC = (g == 1) ? 16 : 4;
    localparam logic [31:0] RB = (g == 1) ? 32'h0 : 32'h100;
    logic rst = 0, miso = 0, prev_sck = 0, prev_csn = 1;
    logic sck, csn, mosi, done, sel;
    logic [31:0] cmd = 0;
    logic [67:0] wr;
    logic [67:0] obs[$];
    logic [7:0] img[64];
    int cyc, cnt, rises, csn_falls, sel_cyc, waitc, stall, fall_cyc, rise1_cyc, bad_mosi;
    flash_loader_if bus();
    flash_loader #(.FLASH_OFFSET(24'h100000), .WORD_COUNT(WC), .RAM_BASE(RB), .CLK_DIV(CD)) dut (
      .clk(clk), .reset(rst), .flash_clk_out(sck), .flash_csn_out(csn), .flash_mosi_out(mosi),
      .flash_miso_in(miso), .bus(bus), .done_out(done));
    assign sel = bus.sel_out;
    assign wr = {bus.address_out, bus.write_value_out, bus.write_mask_out};
    // flash model, RAM responder and activity counters, all sampled mid-cycle
    always @(negedge clk) begin
      int d;
      cyc++;
      if (prev_csn && !csn) begin
        csn_falls++;
        fall_cyc = cyc;
      end
      if (sck && !prev_sck) rises++;
      if (csn) cnt = 0;
      else if (sck && !prev_sck) begin
        if (cnt == 0) rise1_cyc = cyc;
        if (cnt < 32) cmd = {cmd[30:0], mosi};
        else if (mosi) bad_mosi++;
        cnt++;
      end else if (!sck && prev_sck && cnt >= 32) begin
        d = cnt - 32;
        miso = img[(d / 8) % (4 * WC)][7 - d % 8];
      end
      if (sel) begin
        sel_cyc++;
        bus.ready_in = waitc >= stall;
        waitc++;
        if (bus.ready_in) obs.push_back(wr);
      end else begin
        waitc = 0;
        bus.ready_in = 0;
      end
      prev_sck = sck;
      prev_csn = csn;
    end
  end

  task test_reset;
    g_dut[0].stall = 5;
    for (int i = 0; i < 64; i++) g_dut[0].img[i] = i < 8 ? pat[i] : 8'($urandom);
    for (int w = 0; w < 4; w++)
      exp_a.push_back({32'h100 + 32'(4 * w), g_dut[0].img[4*w+3], g_dut[0].img[4*w+2],
                       g_dut[0].img[4*w+1], g_dut[0].img[4*w], 4'hf});
    #3;
    g_dut[0].rst = 1;
    g_dut[1].rst = 1;
    #1;
    n_chk++;
    if ({g_dut[0].sck, g_dut[0].csn, g_dut[0].mosi, g_dut[0].done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_spi: got %b expected 0100", {g_dut[0].sck, g_dut[0].csn, g_dut[0].mosi, g_dut[0].done});
    end
    n_chk++;
    if ({g_dut[0].sel, g_dut[0].wr} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h expected 0", {g_dut[0].sel, g_dut[0].wr});
    end
    n_chk++;
    if ({g_dut[1].sck, g_dut[1].csn, g_dut[1].mosi, g_dut[1].done, g_dut[1].sel, g_dut[1].wr} !== {4'b0100, 69'd0}) begin
      n_fail++;
      $display("FAIL reset_b: got %h", {g_dut[1].sck, g_dut[1].csn, g_dut[1].mosi, g_dut[1].done, g_dut[1].sel, g_dut[1].wr});
    end
  endtask

  task test_framing;
    repeat (3) @(negedge clk);
    g_dut[0].rst = 0;
    for (int i = 0; i < 1000 && g_dut[0].rises < 32; i++) @(negedge clk);
    n_chk++;
    if (g_dut[0].cmd !== 32'h03100000) begin
      n_fail++;
      $display("FAIL cmd_frame: got %h expected 03100000", g_dut[0].cmd);
    end
    n_chk++;
    if (g_dut[0].csn_falls !== 1) begin
      n_fail++;
      $display("FAIL cs_fall_count: got %0d expected 1", g_dut[0].csn_falls);
    end
    n_chk++;
    if (g_dut[0].rise1_cyc - g_dut[0].fall_cyc !== 2) begin
      n_fail++;
      $display("FAIL first_rise_delay: got %0d expected 2", g_dut[0].rise1_cyc - g_dut[0].fall_cyc);
    end
  endtask

  task test_backpressure;
    logic [67:0] snap;
    int n, bad, r0;
    for (int i = 0; i < 1000 && !g_dut[0].sel; i++) @(negedge clk);
    snap = g_dut[0].wr;
    r0 = g_dut[0].rises;
    n = 0;
    bad = 0;
    while (g_dut[0].sel && n < 50) begin
      if (g_dut[0].wr !== snap || g_dut[0].sck !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    g_dut[0].stall = 0;
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad);
    end
    n_chk++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL stall_sel_len: got %0d expected 6", n);
    end
    n_chk++;
    if (g_dut[0].rises !== r0) begin
      n_fail++;
      $display("FAIL stall_no_sck: got %0d rises expected %0d", g_dut[0].rises, r0);
    end
  endtask

  task test_completion;
    logic [67:0] e;
    for (int i = 0; i < 3000 && !g_dut[0].done; i++) @(negedge clk);
    n_chk++;
    if ({g_dut[0].done, g_dut[0].csn} !== 2'b11) begin
      n_fail++;
      $display("FAIL done_cs: got %b expected 11", {g_dut[0].done, g_dut[0].csn});
    end
    n_chk++;
    if (g_dut[0].csn_falls !== 1 || g_dut[0].bad_mosi !== 0) begin
      n_fail++;
      $display("FAIL cs_mosi_data: got falls %0d mosi_ones %0d expected 1 0", g_dut[0].csn_falls, g_dut[0].bad_mosi);
    end
    for (int w = 0; w < 4; w++) begin
      e = exp_a.pop_front();
      n_chk++;
      if (g_dut[0].obs[w] !== e) begin
        n_fail++;
        $display("FAIL write_a%0d: got %h expected %h", w, g_dut[0].obs[w], e);
      end
    end
    n_chk++;
    if (g_dut[0].rises !== 160) begin
      n_fail++;
      $display("FAIL sck_total: got %0d expected 160", g_dut[0].rises);
    end
    repeat (40) @(negedge clk);
    n_chk++;
    if (g_dut[0].rises !== 160 || g_dut[0].sel_cyc !== 9 || g_dut[0].done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_quiet: got rises %0d sel_cycles %0d done %b expected 160 9 1",
               g_dut[0].rises, g_dut[0].sel_cyc, g_dut[0].done);
    end
  endtask

  task test_mid_reset;
    logic [67:0] e;
    int base, nb;
    @(negedge clk);
    #2 g_dut[0].rst = 1;
    repeat (2) @(negedge clk);
    g_dut[0].rst = 0;
    base = g_dut[0].rises;
    for (int i = 0; i < 1000 && g_dut[0].rises - base < 76; i++) @(negedge clk);
    #2 g_dut[0].rst = 1;
    #1;
    n_chk++;
    if ({g_dut[0].sck, g_dut[0].csn, g_dut[0].mosi, g_dut[0].done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midreset_spi: got %b expected 0100", {g_dut[0].sck, g_dut[0].csn, g_dut[0].mosi, g_dut[0].done});
    end
    n_chk++;
    if ({g_dut[0].sel, g_dut[0].wr} !== 69'd0) begin
      n_fail++;
      $display("FAIL midreset_bus: got %h expected 0", {g_dut[0].sel, g_dut[0].wr});
    end
    nb = g_dut[0].obs.size();
    exp_a.push_back({32'h100, g_dut[0].img[3], g_dut[0].img[2], g_dut[0].img[1], g_dut[0].img[0], 4'hf});
    repeat (3) @(negedge clk);
    g_dut[0].rst = 0;
    base = g_dut[0].rises;
    for (int i = 0; i < 1000 && g_dut[0].rises - base < 32; i++) @(negedge clk);
    n_chk++;
    if (g_dut[0].cmd !== 32'h03100000) begin
      n_fail++;
      $display("FAIL restart_cmd: got %h expected 03100000", g_dut[0].cmd);
    end
    for (int i = 0; i < 1000 && g_dut[0].obs.size() <= nb; i++) @(negedge clk);
    e = exp_a.pop_front();
    n_chk++;
    if (g_dut[0].obs[nb] !== e) begin
      n_fail++;
      $display("FAIL restart_word0: got %h expected %h", g_dut[0].obs[nb], e);
    end
  endtask

  task test_random_image;
    logic [67:0] e;
    for (int i = 0; i < 64; i++) g_dut[1].img[i] = i < 8 ? pat[i] : 8'($urandom);
    for (int w = 0; w < 16; w++)
      exp_b.push_back({32'(4 * w), g_dut[1].img[4*w+3], g_dut[1].img[4*w+2],
                       g_dut[1].img[4*w+1], g_dut[1].img[4*w], 4'hf});
    @(negedge clk);
    g_dut[1].rst = 0;
    for (int i = 0; i < 4000 && !g_dut[1].done; i++) @(negedge clk);
    for (int w = 0; w < 16; w++) begin
      e = exp_b.pop_front();
      n_chk++;
      if (g_dut[1].obs[w] !== e) begin
        n_fail++;
        $display("FAIL write_b%0d: got %h expected %h", w, g_dut[1].obs[w], e);
      end
    end
    n_chk++;
    if (g_dut[1].rises !== 544 || g_dut[1].cmd !== 32'h03100000 || g_dut[1].bad_mosi !== 0) begin
      n_fail++;
      $display("FAIL b_framing: got rises %0d cmd %h mosi_ones %0d expected 544 03100000 0",
               g_dut[1].rises, g_dut[1].cmd, g_dut[1].bad_mosi);
    end
  endtask

  initial begin
    test_reset();
    test_framing();
    test_backpressure();
    test_completion();
    test_mid_reset();
    test_random_image();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flash_loader.md
# flash_loader

Boot-time copier between the SPI flash and on-chip RAM. After reset it reads a fixed image from the SPI flash with a single continuous READ (0x03) command and writes it word-by-word into RAM as a memory-bus master. It asserts `done_out` when the copy is complete; the CPU is held off until then. It sits upstream of the RAM and is used in `SPI_FLASH` builds, where RAM has no preloaded image.

## Interface
- `FLASH_OFFSET`, 24'h100000: flash byte address of the image's first byte.
- `WORD_COUNT`, 2048: number of 32-bit words copied; must be ≥1.
- `RAM_BASE`, 32'h0: bus address of the first RAM word; word-aligned.
- `CLK_DIV`, 2: `clk` cycles per SCK half-period; must be ≥1.

- `clk`  in  1  system clock; sole clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `flash_clk_out`  out  1  SPI SCK, mode 0 (idle low).
- `flash_csn_out`  out  1  SPI chip select, active low.
- `flash_mosi_out`  out  1  SPI data to flash.
- `flash_miso_in`  in  1  SPI data from flash.
- `address_out`  out  32  bus byte address.
- `sel_out`  out  1  bus select / request.
- `write_mask_out`  out  4  byte write enables.
- `write_value_out`  out  32  bus write data.
- `ready_in`  in  1  bus acknowledge.
- `done_out`  out  1  copy complete; sticky until reset.

## Operation
- States: START → CMD → ADDR → DATA → WRITE → (DATA | FINISH) → DONE.
- START: one cycle after reset deasserts; drives `flash_csn_out`=0.
- CMD: shifts 8'h03 out MSB first.
- ADDR: shifts `FLASH_OFFSET[23:0]` out MSB first.
- DATA: clocks in 4 bytes, each MSB first.
  - Byte k (k=0..3) of a word lands in `write_value_out[8k+7:8k]` (little-endian; first flash byte is the least significant byte).
- WORD COUNTER: word index counter is $clog2(WORD_COUNT)+1 bits wide.
- WRITE:
  - SCK held low.
  - Drives `sel_out`=1, `address_out`=`RAM_BASE`+4×index, `write_mask_out`=4'b1111.
  - Holds all bus outputs stable until `ready_in` is sampled high.
  - On that edge: `sel_out`, `write_mask_out`←0; index increments.
  - If index now equals `WORD_COUNT`, go to FINISH; else resume DATA.
- FINISH: `flash_csn_out`←1; next cycle `done_out`←1, then DONE.
- DONE: terminal. No further SCK or bus activity.
- CS is not released between words; the flash auto-increments its address. `FLASH_OFFSET`+4×`WORD_COUNT` ≤ 2^24 is a parameter constraint and is not checked.
- Reset at any point asynchronously forces all outputs to reset values and discards the partial word. The sequence restarts from START after release.

## Timing
- Reset values:
  - `flash_clk_out`=0, `flash_csn_out`=1, `flash_mosi_out`=0
  - `sel_out`=0, `address_out`=0, `write_mask_out`=0, `write_value_out`=0
  - `done_out`=0
- Bit cell: SCK low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - MOSI changes only when SCK goes low (including the first bit, set with CS).
  - MISO is captured on the `clk` edge that drives SCK high.
- The first SCK rise follows the CS fall by `CLK_DIV` cycles.
- The bus write starts on the cycle after the 32nd data bit's SCK high phase ends.
  - Minimum `sel_out` duration is 1 cycle, when `ready_in` is already high.
  - SCK resumes (low phase) the cycle after acceptance.
- MOSI is 0 during DATA.
- Total SCK rising edges: 32 + 32×`WORD_COUNT`.
- With `ready_in` tied high: done latency ≈ (32+32×WORD_COUNT)×2×CLK_DIV + 2×WORD_COUNT + 4 cycles.

## Test plan
- Command framing (CLK_DIV=2, FLASH_OFFSET=24'h100000): sample MOSI on SCK rises -> first 32 bits = 0x03100000. CS goes low once and SCK idles low.
- Data packing: flash model returns 0x13,0x00,0x00,0x00,0x6F,0x00,0x00,0x00 (WORD_COUNT=2) -> two writes: 0x00000013 to addr 0x0, then 0x0000006F to addr 0x4, mask 4'b1111 each.
- Backpressure: `ready_in` held low 5 cycles on word 0 -> `sel_out` and `address_out`/`write_value_out` stay stable; no SCK edges. Transfer resumes after acceptance with correct data.
- Completion (WORD_COUNT=4, RAM_BASE=32'h100) -> writes to 0x100/0x104/0x108/0x10C, 160 SCK rises total. CS returns high, then `done_out`=1 held; no further `sel_out`.
- Mid-transfer reset (during word 1's 2nd byte) -> all outputs at reset values immediately. After release the sequence restarts with 0x03 and word 0 at `RAM_BASE`.
- CLK_DIV=1 run with random image (WORD_COUNT=16) -> RAM model contents equal image byte-for-byte (little-endian words).
